// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: state encodings and default tile geometry shared by
// the ping-pong MAC tile scheduler and its lane trackers.
package mac_sched_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] RUN   = 3'd1;
    localparam logic [2:0] STALL = 3'd2;
    localparam logic [2:0] FLUSH = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int DEF_DOT_LEN   = 53;
    localparam int DEF_NUM_TILES = 4;

endpackage

// File: rtl/mac_lane_tracker.sv
// mac_lane_tracker: pending-result flag, clear pulse and free flag for
// one local accumulator lane.
module mac_lane_tracker (
    input  logic clk_i,
    input  logic rst_i,
    input  logic set_i,
    input  logic hs_i,
    output logic pend_nxt_o,
    output logic clear_o,
    output logic free_o
);

    logic pend_q;
    logic pend_d;
    logic clear_q;
    logic clear_d;

    always_comb begin
        pend_d  = set_i | (pend_q & ~hs_i);
        clear_d = hs_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            clear_q <= clear_d;
        end
    end

    // Free means the lane is neither pending nor clearing in the next cycle.
    assign pend_nxt_o = pend_d;
    assign clear_o    = clear_q;
    assign free_o     = ~pend_d & ~clear_d;

endmodule

// File: rtl/mac_pingpong_scheduler.sv
// mac_pingpong_scheduler: alternates dot-product tiles between two MAC lanes
// and drains finished lanes over valid/ready. Optional: MAC_SCHED_PERF_EN.
module mac_pingpong_scheduler
    import mac_sched_pkg::*;
#(
    parameter int DOT_LEN   = DEF_DOT_LEN,
    parameter int NUM_TILES = DEF_NUM_TILES,
    parameter int CNT_W     = 9,
    parameter int TILE_W    = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              drain_ready_i,
    output logic              local_en_0,
    output logic              local_en_1,
    output logic              clear_local_0,
    output logic              clear_local_1,
    output logic              drain_valid_o,
    output logic              drain_sel_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic              busy_o,
`ifdef MAC_SCHED_PERF_EN
    output logic [15:0]       stall_cnt_o,
`endif
    output logic              done_o
);

    logic [2:0]        state_q, state_d;
    logic [TILE_W-1:0] tile_q, tile_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic [1:0]        en_q, en_d;
    logic              dv_q, dv_d;
    logic              sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic       lane;
    logic       last_mac;
    logic       hs;
    logic [1:0] set_pend;
    logic [1:0] hs_lane;
    logic [1:0] pend_nxt;
    logic [1:0] clear;
    logic [1:0] free;

    assign lane     = tile_q[0];
    assign last_mac = (state_q == RUN) && (cnt_q == CNT_W'(DOT_LEN - 1));
    assign set_pend = {last_mac & lane, last_mac & ~lane};
    assign hs       = dv_q & drain_ready_i;
    assign hs_lane  = {hs & ptr_q, hs & ~ptr_q};

    mac_lane_tracker u_lane0 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (set_pend[0]),
        .hs_i       (hs_lane[0]),
        .pend_nxt_o (pend_nxt[0]),
        .clear_o    (clear[0]),
        .free_o     (free[0])
    );

    mac_lane_tracker u_lane1 (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .set_i      (set_pend[1]),
        .hs_i       (hs_lane[1]),
        .pend_nxt_o (pend_nxt[1]),
        .clear_o    (clear[1]),
        .free_o     (free[1])
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            tile_q  <= '0;
            cnt_q   <= '0;
            ptr_q   <= 1'b0;
            en_q    <= 2'b00;
            dv_q    <= 1'b0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            en_q    <= en_d;
            dv_q    <= dv_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tile_d  = tile_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    tile_d  = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (last_mac) begin
                    cnt_d = '0;
                    if (tile_q == TILE_W'(NUM_TILES - 1)) begin
                        state_d = FLUSH;
                    end else if (free[~lane]) begin
                        tile_d = tile_q + TILE_W'(1);
                    end else begin
                        state_d = STALL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STALL: begin
                if (free[~lane]) begin
                    state_d = RUN;
                    tile_d  = tile_q + TILE_W'(1);
                end
            end
            FLUSH: begin
                if (&free) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                tile_d  = '0;
            end
            default: begin
                state_d = IDLE;
                tile_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so they line up with state.
    always_comb begin
        en_d = 2'b00;
        if (state_d == RUN) begin
            en_d[tile_d[0]] = 1'b1;
        end
        ptr_d  = (state_q == IDLE) ? 1'b0 : (ptr_q ^ hs);
        dv_d   = |pend_nxt;
        sel_d  = ptr_d;
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign local_en_0    = en_q[0];
    assign local_en_1    = en_q[1];
    assign clear_local_0 = clear[0];
    assign clear_local_1 = clear[1];
    assign drain_valid_o = dv_q;
    assign drain_sel_o   = sel_q;
    assign tile_idx_o    = tile_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

`ifdef MAC_SCHED_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == IDLE) && start_i) begin
            stall_cnt_d = '0;
        end else if ((state_q == STALL) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mac_pingpong_scheduler.sv
// tb_mac_pingpong_scheduler: random and directed stimulus against a
// queue-based behavioural model of the ping-pong tile scheduler.
module tb_mac_pingpong_scheduler;

    localparam int DOT_LEN = 53;
    localparam int LOGN    = 400;
    localparam int B_EN0 = 8;
    localparam int B_EN1 = 9;
    localparam int B_CL0 = 10;
    localparam int B_CL1 = 11;
    localparam int B_DV  = 12;
    localparam int B_BSY = 13;
    localparam int B_DN  = 14;

    logic clk, rst4, rst1, start, ready;
    logic en04, en14, cl04, cl14, dv4, sel4, busy4, done4;
    logic en01, en11, cl01, cl11, dv1, sel1, busy1, done1;
    logic [7:0] tile4, tile1;
`ifdef MAC_SCHED_PERF_EN
    logic [15:0] sc4, sc1;
`endif

    int tests = 0;
    int fails = 0;
    int ecount = 0;
    int base = 1000000;
    int cc;

    logic [14:0] lg4 [0:LOGN-1];
    logic [14:0] mlg4 [0:LOGN-1];
    logic [14:0] lg1 [0:LOGN-1];

    mac_pingpong_scheduler #(.NUM_TILES(4)) u4 (
        .clk_i(clk), .rst_i(rst4), .start_i(start), .drain_ready_i(ready),
        .local_en_0(en04), .local_en_1(en14),
        .clear_local_0(cl04), .clear_local_1(cl14),
        .drain_valid_o(dv4), .drain_sel_o(sel4), .tile_idx_o(tile4),
        .busy_o(busy4),
`ifdef MAC_SCHED_PERF_EN
        .stall_cnt_o(sc4),
`endif
        .done_o(done4)
    );

    mac_pingpong_scheduler #(.NUM_TILES(1)) u1 (
        .clk_i(clk), .rst_i(rst1), .start_i(start), .drain_ready_i(ready),
        .local_en_0(en01), .local_en_1(en11),
        .clear_local_0(cl01), .clear_local_1(cl11),
        .drain_valid_o(dv1), .drain_sel_o(sel1), .tile_idx_o(tile1),
        .busy_o(busy1),
`ifdef MAC_SCHED_PERF_EN
        .stall_cnt_o(sc1),
`endif
        .done_o(done1)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: lane in use, completed products, FIFO of pending lanes.
    bit       m_act [2];
    bit       m_want [2];
    bit       m_done [2];
    bit [1:0] m_clr [2];
    int       m_en [2] = '{-1, -1};
    int       m_acc [2];
    int       m_tile [2];
    int       m_fin [2];
    int       m_pn [2];
    int       m_pq [2][2];

    function automatic int ntiles(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    task automatic mstep(input int i, input bit st, input bit rd, input bit rs);
        bit [1:0] nc;
        int tgt;
        bit inq;
        nc = 2'b00;
        if (rs) begin
            m_act[i] = 0; m_want[i] = 0; m_done[i] = 0; m_clr[i] = 0;
            m_en[i] = -1; m_acc[i] = 0; m_tile[i] = 0; m_fin[i] = 0;
            m_pn[i] = 0;
            return;
        end
        if (!m_act[i]) begin
            if (st) begin
                m_act[i] = 1; m_tile[i] = 0; m_acc[i] = 0;
                m_fin[i] = 0; m_en[i] = 0; m_want[i] = 0;
            end
        end else if (m_done[i]) begin
            m_act[i] = 0; m_done[i] = 0; m_tile[i] = 0;
        end else begin
            if (m_pn[i] > 0 && rd) begin
                nc[m_pq[i][0]] = 1'b1;
                m_pq[i][0] = m_pq[i][1];
                m_pn[i]--;
            end
            if (m_en[i] >= 0) begin
                m_acc[i]++;
                if (m_acc[i] == DOT_LEN) begin
                    m_pq[i][m_pn[i]] = m_en[i];
                    m_pn[i]++;
                    m_fin[i]++;
                    m_en[i] = -1;
                    m_want[i] = m_fin[i] < ntiles(i);
                end
            end
            if (m_want[i]) begin
                tgt = (m_tile[i] + 1) % 2;
                inq = 0;
                for (int k = 0; k < m_pn[i]; k++)
                    if (m_pq[i][k] == tgt) inq = 1;
                if (!inq && !nc[tgt]) begin
                    m_tile[i]++; m_en[i] = tgt; m_acc[i] = 0; m_want[i] = 0;
                end
            end else if (m_en[i] < 0 && m_fin[i] == ntiles(i) &&
                         m_pn[i] == 0 && nc == 2'b00) begin
                m_done[i] = 1;
            end
        end
        m_clr[i] = nc;
    endtask

    function automatic logic [14:0] mvec(input int i);
        return {m_done[i], m_act[i], (m_pn[i] > 0), m_clr[i][1], m_clr[i][0],
                (m_en[i] == 1), (m_en[i] == 0), 8'(m_tile[i])};
    endfunction

    function automatic logic [14:0] g4();
        return {done4, busy4, dv4, cl14, cl04, en14, en04, tile4};
    endfunction

    function automatic logic [14:0] g1();
        return {done1, busy1, dv1, cl11, cl01, en11, en01, tile1};
    endfunction

    initial forever begin
        @(posedge clk);
        mstep(0, start, ready, rst4);
        mstep(1, start, ready, rst1);
        ecount++;
    end

    task automatic inv(input string nm, input bit bad);
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL %s t=%0t got=1 want=0", nm, $time);
        end
    endtask

    task automatic cmp(input string nm, input int i, input logic [14:0] got, input bit sel);
        logic [14:0] e;
        e = mvec(i);
        tests++;
        if (got !== e) begin
            fails++;
            $display("FAIL %s t=%0t got=%h want=%h", nm, $time, got, e);
        end
        if (m_pn[i] > 0) begin
            tests++;
            if (sel !== m_pq[i][0][0]) begin
                fails++;
                $display("FAIL %s_sel t=%0t got=%0d want=%0d", nm, $time, sel, m_pq[i][0]);
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        cmp("u4_outputs", 0, g4(), sel4);
        cmp("u1_outputs", 1, g1(), sel1);
        inv("u4_en0_clr0", en04 && cl04);
        inv("u4_en1_clr1", en14 && cl14);
        inv("u4_en_both", en04 && en14);
        inv("u1_en0_clr0", en01 && cl01);
        inv("u1_en1_clr1", en11 && cl11);
        inv("u1_en_both", en01 && en11);
        cc = ecount - base + 1;
        if (cc >= 1 && cc < LOGN) begin
            lg4[cc] = g4();
            mlg4[cc] = mvec(0);
            lg1[cc] = g1();
        end
    end

    task automatic lit(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", nm, got, exp);
        end
    endtask

    task automatic launch();
        @(negedge clk); #1;
        for (int k = 0; k < LOGN; k++) begin
            lg4[k] = '0; mlg4[k] = '0; lg1[k] = '0;
        end
        base = ecount + 1;
        start = 1;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        ready = 1;
        while ((m_act[0] || m_act[1]) && k < 5000) begin
            @(negedge clk); #1;
            k++;
        end
        tests++;
        if (m_act[0] || m_act[1]) begin
            fails++;
            $display("FAIL idle_timeout got=busy want=idle");
        end
    endtask

    task automatic run_cycles(input int n, input int mode);
        int c;
        for (int k = 0; k < n; k++) begin
            @(negedge clk); #1;
            c = ecount - base + 1;
            if (mode == 2) ready = (c >= 150);
            if (mode == 3) start = (c == 20);
        end
        start = 0;
    endtask

    initial begin
        int anyen1;
        int p;
        rst4 = 1; rst1 = 1; start = 0; ready = 0;
        repeat (2) @(posedge clk);
        #1;
        lit("reset_state_u4", int'(g4()), 0);
        lit("reset_state_u1", int'(g1()), 0);
        @(negedge clk); #1;
        rst4 = 0; rst1 = 0;

        ready = 1;
        launch();
        run_cycles(230, 0);
        lit("s1_en0_c1", lg4[1][B_EN0], 1);
        lit("s1_en0_c53", lg4[53][B_EN0], 1);
        lit("s1_en0_c54", lg4[54][B_EN0], 0);
        lit("s1_en1_c54", lg4[54][B_EN1], 1);
        lit("s1_en1_c106", lg4[106][B_EN1], 1);
        lit("s1_en0_c107", lg4[107][B_EN0], 1);
        lit("s1_en0_c159", lg4[159][B_EN0], 1);
        lit("s1_en1_c160", lg4[160][B_EN1], 1);
        lit("s1_en1_c212", lg4[212][B_EN1], 1);
        lit("s1_en1_c213", lg4[213][B_EN1], 0);
        lit("s1_clr0_c55", lg4[55][B_CL0], 1);
        lit("s1_clr0_c161", lg4[161][B_CL0], 1);
        lit("s1_clr1_c108", lg4[108][B_CL1], 1);
        lit("s1_clr1_c214", lg4[214][B_CL1], 1);
        lit("s1_done_c214", lg4[214][B_DN], 0);
        lit("s1_done_c215", lg4[215][B_DN], 1);
        lit("s1_done_c216", lg4[216][B_DN], 0);
        lit("s1_model_done_c215", mlg4[215][B_DN], 1);
        lit("s1_model_clr0_c55", mlg4[55][B_CL0], 1);
        lit("n1_en0_c1", lg1[1][B_EN0], 1);
        lit("n1_en0_c53", lg1[53][B_EN0], 1);
        lit("n1_dv_c54", lg1[54][B_DV], 1);
        lit("n1_clr0_c55", lg1[55][B_CL0], 1);
        lit("n1_done_c55", lg1[55][B_DN], 0);
        lit("n1_done_c56", lg1[56][B_DN], 1);
        anyen1 = 0;
        for (int k = 1; k < LOGN; k++) anyen1 |= int'(lg1[k][B_EN1]);
        lit("n1_en1_never", anyen1, 0);

        wait_idle();
        ready = 0;
        launch();
        run_cycles(300, 2);
        lit("s2_en1_c106", lg4[106][B_EN1], 1);
        lit("s2_en1_c107", lg4[107][B_EN1], 0);
        lit("s2_en0_c130", lg4[130][B_EN0], 0);
        lit("s2_dv_c130", lg4[130][B_DV], 1);
        lit("s2_tile_c130", int'(lg4[130][7:0]), 1);
        lit("s2_en0_c151", lg4[151][B_EN0], 0);
        lit("s2_clr0_c151", lg4[151][B_CL0], 1);
        lit("s2_clr1_c152", lg4[152][B_CL1], 1);
        lit("s2_en0_c152", lg4[152][B_EN0], 1);
        lit("s2_en0_c204", lg4[204][B_EN0], 1);
        lit("s2_en0_c205", lg4[205][B_EN0], 0);
        lit("s2_tile_c152", int'(lg4[152][7:0]), 2);

        wait_idle();
        launch();
        run_cycles(230, 3);
        lit("s3_tile_c100", int'(lg4[100][7:0]), 1);
        lit("s3_en1_c160", lg4[160][B_EN1], 1);
        lit("s3_done_c215", lg4[215][B_DN], 1);
        lit("s3_done_c214", lg4[214][B_DN], 0);

        wait_idle();
        launch();
        while (ecount - base + 1 < 80) @(negedge clk);
        #2 rst4 = 1;
        #1;
        lit("s4_async_reset", int'(g4()), 0);
        lit("s4_en1_c80", lg4[80][B_EN1], 1);
        @(negedge clk); #1;
        rst4 = 0;
        wait_idle();
        launch();
        run_cycles(60, 0);
        lit("s4_tile_c1", int'(lg4[1][7:0]), 0);
        lit("s4_en0_c1", lg4[1][B_EN0], 1);
        lit("s4_en0_c53", lg4[53][B_EN0], 1);
        lit("s4_en0_c54", lg4[54][B_EN0], 0);
        lit("s4_en1_c54", lg4[54][B_EN1], 1);

        wait_idle();
        for (int j = 0; j < 25; j++) begin
            p = $urandom_range(1, 4);
            start = 1;
            for (int k = 0; k < 400; k++) begin
                @(negedge clk); #1;
                if (k > 0) start = ($urandom_range(0, 40) == 0);
                ready = ($urandom_range(0, 3) < p);
                if (rst4) rst4 = 0;
                else if ($urandom_range(0, 799) == 0) rst4 = 1;
                if (rst1) rst1 = 0;
                else if ($urandom_range(0, 799) == 0) rst1 = 1;
            end
        end
        start = 0; rst4 = 0; rst1 = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
